// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_pkg
// Brief    : Shared types and sizing helpers for the Booth multiplier datapath.
// Revision : 1.0 - initial release
// ============================================================================
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Encoder and accumulator both size themselves from this helper so the
    // slice count cannot drift between the two.
    function automatic int num_terms(input int width);
        return (width + 3) / 3;
    endfunction

    localparam int c_default_data_width = 32;
    localparam int c_default_num_terms  = num_terms(c_default_data_width);
    localparam int c_first_slice        = 0;
    localparam int c_last_slice         = c_default_num_terms - 1;

endpackage
`default_nettype wire

// File: rtl/pp_slice_mux.sv
`default_nettype none
// ============================================================================
// Module   : pp_slice_mux
// Brief    : Selects one partial-product slice and sign-extends it to product width.
// Revision : 1.0 - initial release
// ============================================================================
module pp_slice_mux
    import booth_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_TERMS   = num_terms(DATA_WIDTH),
    parameter int SLICE_WIDTH = 2 * DATA_WIDTH - 1,
    parameter int CAPACITY    = SLICE_WIDTH * NUM_TERMS,
    parameter int CNT_WIDTH   = $clog2(NUM_TERMS + 1)
) (
    input  logic [CAPACITY-1:0]     pp_reg,
    input  logic [CNT_WIDTH-1:0]    term_cnt,
    output logic [2*DATA_WIDTH-1:0] slice_sext
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    logic [SLICE_WIDTH-1:0] w_slices [NUM_TERMS];
    logic [SLICE_WIDTH-1:0] w_sel;

    genvar gi;
    for (gi = c_first_slice; gi < NUM_TERMS; gi++) begin : g_slice
        assign w_slices[gi] = pp_reg[gi*SLICE_WIDTH +: SLICE_WIDTH];
    end

    // Out-of-range counts select zero so the adder sees a harmless operand.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_TERMS; i++) begin
            if (term_cnt == CNT_WIDTH'(i)) begin
                w_sel = w_slices[i];
            end
        end
    end

    assign slice_sext = PROD_WIDTH'($signed(w_sel));

endmodule
`default_nettype wire

// File: rtl/booth_pp_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : booth_pp_accumulator
// Brief    : Serially sums packed Booth partial products, one slice per clock.
// Revision : 1.0 - initial release
// ============================================================================
module booth_pp_accumulator
    import booth_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_TERMS   = num_terms(DATA_WIDTH),
    parameter int SLICE_WIDTH = 2 * DATA_WIDTH - 1,
    parameter int CAPACITY    = SLICE_WIDTH * NUM_TERMS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CAPACITY-1:0]     pp_bus,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] product,
    output logic                    busy
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int CNT_WIDTH  = $clog2(NUM_TERMS + 1);
    localparam logic [CNT_WIDTH-1:0] c_last_term = CNT_WIDTH'(NUM_TERMS - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [CAPACITY-1:0]   r_pp_reg;
    logic [PROD_WIDTH-1:0] r_acc;
    logic [PROD_WIDTH-1:0] w_slice_sext;
    logic [CNT_WIDTH-1:0]  r_term_cnt;
    logic                  w_accept;
    logic                  w_last_add;

    pp_slice_mux #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_TERMS   (NUM_TERMS),
        .SLICE_WIDTH (SLICE_WIDTH),
        .CAPACITY    (CAPACITY),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_slice_mux (
        .pp_reg     (r_pp_reg),
        .term_cnt   (r_term_cnt),
        .slice_sext (w_slice_sext)
    );

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_last_add   = (r_term_cnt == c_last_term);
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ACCUM;
                end
            end
            ACCUM: begin
                if (w_last_add) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pp_reg   <= '0;
            r_acc      <= '0;
            r_term_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_pp_reg   <= pp_bus;
                r_acc      <= '0;
                r_term_cnt <= '0;
            end else if (r_state == ACCUM) begin
                r_acc      <= r_acc + w_slice_sext;
                r_term_cnt <= r_term_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Every output is a decode of state or a register, never of a live input.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == ACCUM) || (r_state == DONE);
    assign product   = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_booth_pp_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_pp_accumulator
// Brief    : Scoreboard bench for booth_pp_accumulator at DATA_WIDTH = 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_pp_accumulator;

    localparam int DW  = 8;
    localparam int NT  = 3;
    localparam int SW  = 15;
    localparam int CAP = SW * NT;
    localparam int PW  = 2 * DW;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [CAP-1:0] pp_bus;
    logic           out_valid;
    logic           out_ready;
    logic [PW-1:0]  product;
    logic           busy;

    int n_cmp;
    int n_err;
    logic [PW-1:0] sb_q[$];

    booth_pp_accumulator #(
        .DATA_WIDTH  (DW),
        .NUM_TERMS   (NT),
        .SLICE_WIDTH (SW),
        .CAPACITY    (CAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp_bus    (pp_bus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] model(input logic [SW-1:0] s0,
                                            input logic [SW-1:0] s1,
                                            input logic [SW-1:0] s2);
        logic [SW-1:0] s [3];
        int total;
        logic [31:0] t;
        s[0] = s0; s[1] = s1; s[2] = s2;
        total = 0;
        for (int i = 0; i < 3; i++) begin
            if (s[i][SW-1]) total += int'(s[i]) - (1 << SW);
            else            total += int'(s[i]);
        end
        t = 32'(total);
        return t[PW-1:0];
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (!in_ready) begin
            n_err++;
            $display("FAIL wait_ready: in_ready=%0b required 1 within 50 cycles", in_ready);
        end
    endtask

    // Accepts one bus, checks latency, product and return to IDLE.
    task automatic run_txn(input string name, input logic [SW-1:0] s0,
                           input logic [SW-1:0] s1, input logic [SW-1:0] s2);
        int lat;
        logic [PW-1:0] exp_p;
        wait_ready();
        pp_bus   = {s2, s1, s0};
        in_valid = 1'b1;
        sb_q.push_back(model(s0, s1, s2));
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s_busy: in_ready=%0b busy=%0b required 0/1", name, in_ready, busy);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat != NT) begin
            n_err++;
            $display("FAIL %s_latency: got %0d cycles required %0d", name, lat, NT);
        end
        exp_p = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
        n_cmp++;
        if (product !== exp_p) begin
            n_err++;
            $display("FAIL %s_product: got %h required %h", name, product, exp_p);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle: in_ready=%0b out_valid=%0b required 1/0", name, in_ready, out_valid);
        end
    endtask

    task automatic check_reset_vals(input string name);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
            n_err++;
            $display("FAIL %s: in_ready=%0b out_valid=%0b busy=%0b product=%h required 1/0/0/0000",
                     name, in_ready, out_valid, busy, product);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_positive_sum();
        out_ready = 1'b1;
        run_txn("positive", 15'd3, 15'd5, 15'd7);
    endtask

    task automatic test_sign_extension();
        run_txn("signext", 15'h7FFF, 15'h0002, 15'h0000);
        run_txn("negsum", 15'h7FFE, 15'h7FFD, 15'h0001);
    endtask

    task automatic test_wrap();
        run_txn("wrap", 15'h4000, 15'h4000, 15'h4000);
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] exp_p;
        int n;
        wait_ready();
        out_ready = 1'b0;
        pp_bus    = {15'd30, 15'd20, 15'd10};
        in_valid  = 1'b1;
        sb_q.push_back(model(15'd10, 15'd20, 15'd30));
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        exp_p = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== exp_p) begin
                n_err++;
                $display("FAIL backpressure_hold[%0d]: out_valid=%0b in_ready=%0b product=%h required 1/0/%h",
                         c, out_valid, in_ready, product, exp_p);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_release: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_accum();
        wait_ready();
        pp_bus   = {15'd9, 15'd8, 15'd7};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_mid_accum");
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("after_reset_idle");
        run_txn("post_reset", 15'd1, 15'd1, 15'd1);
    endtask

    task automatic test_back_to_back();
        int accepts, outs, edge_n, first_edge, second_edge;
        logic pend;
        logic [PW-1:0] exp_p;
        wait_ready();
        out_ready   = 1'b1;
        pp_bus      = {15'd3, 15'd2, 15'd1};
        in_valid    = 1'b1;
        accepts     = 0;
        outs        = 0;
        edge_n      = 0;
        first_edge  = -1;
        second_edge = -1;
        while (outs < 2 && edge_n < 40) begin
            pend = in_ready && in_valid;
            @(posedge clk); #1;
            edge_n++;
            if (pend) begin
                accepts++;
                if (accepts == 1) begin
                    first_edge = edge_n;
                    sb_q.push_back(model(15'd1, 15'd2, 15'd3));
                    pp_bus = {15'd6, 15'd5, 15'd4};
                end else begin
                    second_edge = edge_n;
                    sb_q.push_back(model(15'd4, 15'd5, 15'd6));
                    in_valid = 1'b0;
                end
            end
            if (out_valid === 1'b1) begin
                exp_p = sb_q.size() > 0 ? sb_q.pop_front() : 'x;
                outs++;
                n_cmp++;
                if (product !== exp_p) begin
                    n_err++;
                    $display("FAIL b2b_product[%0d]: got %h required %h", outs, product, exp_p);
                end
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (outs != 2) begin
            n_err++;
            $display("FAIL b2b_count: got %0d results required 2", outs);
        end
        n_cmp++;
        if (second_edge - first_edge != NT + 2) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d cycles required %0d", second_edge - first_edge, NT + 2);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pp_bus    = '0;
        test_reset();
        test_positive_sum();
        test_sign_extension();
        test_wrap();
        test_backpressure();
        test_reset_mid_accum();
        test_back_to_back();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d left required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
